// File: rtl/matrix_loader_if.sv
// rtl/matrix_loader_if.sv - stream-in / memory-write / multiplier-control bundle for matrix_loader
interface matrix_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic                  start;
    logic                  result_ready;
    logic                  busy;
    logic                  error;

    modport master (
        input  in_data, in_valid, result_ready,
        output in_ready, mem_data, mem_addr, mem_we, start, busy, error
    );

    modport slave (
        output in_data, in_valid, result_ready,
        input  in_ready, mem_data, mem_addr, mem_we, start, busy, error
    );
endinterface

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - validates M/N/P header and writes A/B into the shared memory, then starts the multiplier
// Optional LOADER_TRANSPOSE_B_EN: store B column-major (B base + j*N + k).
module matrix_loader #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int MAX_LEN     = 100,
    parameter int MAX_LEN_LOG = 7
) (
    input  logic            clk,
    input  logic            reset,
    matrix_loader_if.master bus
);
    localparam int PROD_W = 2 * MAX_LEN_LOG;
    // Wide enough that three maximal products plus the header never wrap.
    localparam int SUM_W  = (PROD_W + 2 > ADDR_WIDTH + 2) ? PROD_W + 2 : ADDR_WIDTH + 2;

    localparam logic [DATA_WIDTH-1:0]  MAX_LEN_W = DATA_WIDTH'(MAX_LEN);
    localparam logic [SUM_W-1:0]       CAPACITY  = SUM_W'(1) << ADDR_WIDTH;
    localparam logic [SUM_W-1:0]       HDR_WORDS = SUM_W'(3);
    localparam logic [ADDR_WIDTH-1:0]  A_BASE    = ADDR_WIDTH'(3);
    localparam logic [MAX_LEN_LOG-1:0] CNT_ONE   = MAX_LEN_LOG'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_M,
        S_HDR_N,
        S_HDR_P,
        S_CHECK,
        S_LOAD_A,
        S_LOAD_B,
        S_START,
        S_WAIT,
        S_ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [MAX_LEN_LOG-1:0] m_q, m_d, n_q, n_d, p_q, p_d;
    logic [MAX_LEN_LOG-1:0] row_q, row_d, col_q, col_d;
    logic [ADDR_WIDTH-1:0]  b_base_q, b_base_d;
    logic                   in_ready_q, in_ready_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]  mem_data_q, mem_data_d;
    logic                   start_q, start_d;

    logic                   xfer;
    logic                   dim_ok;
    logic [MAX_LEN_LOG-1:0] dim_word;
    logic [PROD_W-1:0]      prod_mn, prod_np, prod_mp;
    logic [PROD_W-1:0]      a_off, b_off;
    logic [SUM_W-1:0]       need_words;
    logic [MAX_LEN_LOG-1:0] row_lim, col_lim;
    logic                   row_wrap, col_wrap;

    assign xfer     = bus.in_valid && in_ready_q;
    assign dim_ok   = (bus.in_data != '0) && (bus.in_data <= MAX_LEN_W);
    assign dim_word = bus.in_data[MAX_LEN_LOG-1:0];

    assign prod_mn    = PROD_W'(m_q) * PROD_W'(n_q);
    assign prod_np    = PROD_W'(n_q) * PROD_W'(p_q);
    assign prod_mp    = PROD_W'(m_q) * PROD_W'(p_q);
    assign need_words = HDR_WORDS + SUM_W'(prod_mn) + SUM_W'(prod_np) + SUM_W'(prod_mp);

    // A rows span N columns; B rows (indexed by k) span P columns.
    assign row_lim  = (state_q == S_LOAD_B) ? n_q : m_q;
    assign col_lim  = (state_q == S_LOAD_B) ? p_q : n_q;
    assign row_wrap = ((row_q + CNT_ONE) == row_lim);
    assign col_wrap = ((col_q + CNT_ONE) == col_lim);

    assign a_off = PROD_W'(row_q) * PROD_W'(n_q) + PROD_W'(col_q);
`ifdef LOADER_TRANSPOSE_B_EN
    assign b_off = PROD_W'(col_q) * PROD_W'(n_q) + PROD_W'(row_q);
`else
    assign b_off = PROD_W'(row_q) * PROD_W'(p_q) + PROD_W'(col_q);
`endif

    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        n_d        = n_q;
        p_d        = p_q;
        row_d      = row_q;
        col_d      = col_q;
        b_base_d   = b_base_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        start_d    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_HDR_M;

            S_HDR_M, S_HDR_N, S_HDR_P: begin
                if (xfer) begin
                    if (!dim_ok) begin
                        state_d = S_ERR;
                    end else begin
                        mem_we_d   = 1'b1;
                        mem_data_d = bus.in_data;
                        case (state_q)
                            S_HDR_M: begin
                                m_d        = dim_word;
                                mem_addr_d = ADDR_WIDTH'(0);
                                state_d    = S_HDR_N;
                            end
                            S_HDR_N: begin
                                n_d        = dim_word;
                                mem_addr_d = ADDR_WIDTH'(1);
                                state_d    = S_HDR_P;
                            end
                            default: begin
                                p_d        = dim_word;
                                mem_addr_d = ADDR_WIDTH'(2);
                                state_d    = S_CHECK;
                            end
                        endcase
                    end
                end
            end

            S_CHECK: begin
                if (need_words > CAPACITY) begin
                    state_d = S_ERR;
                end else begin
                    row_d    = '0;
                    col_d    = '0;
                    b_base_d = A_BASE + ADDR_WIDTH'(prod_mn);
                    state_d  = S_LOAD_A;
                end
            end

            S_LOAD_A, S_LOAD_B: begin
                if (xfer) begin
                    mem_we_d   = 1'b1;
                    mem_data_d = bus.in_data;
                    mem_addr_d = (state_q == S_LOAD_A) ? A_BASE + ADDR_WIDTH'(a_off)
                                                       : b_base_q + ADDR_WIDTH'(b_off);
                    if (col_wrap) begin
                        col_d = '0;
                        if (row_wrap) begin
                            row_d   = '0;
                            state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_START;
                        end else begin
                            row_d = row_q + CNT_ONE;
                        end
                    end else begin
                        col_d = col_q + CNT_ONE;
                    end
                end
            end

            // The registered start lands one cycle after the last B write.
            S_START: begin
                start_d = 1'b1;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (bus.result_ready) state_d = S_IDLE;
            end

            S_ERR: state_d = S_ERR;

            default: state_d = S_ERR;
        endcase

        in_ready_d = (state_d == S_HDR_M) || (state_d == S_HDR_N) || (state_d == S_HDR_P) ||
                     (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            m_q        <= '0;
            n_q        <= '0;
            p_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            b_base_q   <= '0;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            n_q        <= n_d;
            p_q        <= p_d;
            row_q      <= row_d;
            col_q      <= col_d;
            b_base_q   <= b_base_d;
            in_ready_q <= in_ready_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            start_q    <= start_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_data = mem_data_q;
    assign bus.start    = start_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.error    = (state_q == S_ERR);
endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - randomized stream bench for matrix_loader against a memory-image reference model
module tb_matrix_loader;
    localparam int DW        = 32;
    localparam int AW        = 12;
    localparam int MEM_WORDS = 1 << AW;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    matrix_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    matrix_loader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_LEN    (100),
        .MAX_LEN_LOG(7)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [DW-1:0] wr_mem  [MEM_WORDS];
    bit            wr_flag [MEM_WORDS];
    logic [DW-1:0] exp_mem [MEM_WORDS];
    int wr_cnt, start_cnt, last_wr_cyc, start_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_mem[bus.mem_addr]  = bus.mem_data;
            wr_flag[bus.mem_addr] = 1'b1;
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        if (bus.start === 1'b1) begin
            start_cnt++;
            start_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        for (int i = 0; i < MEM_WORDS; i++) wr_flag[i] = 1'b0;
        wr_cnt      = 0;
        start_cnt   = 0;
        last_wr_cyc = -1;
        start_cyc   = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(0));
        check({tag, "_mem_we"},   64'(bus.mem_we),   64'(0));
        check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(0));
        check({tag, "_mem_data"}, 64'(bus.mem_data), 64'(0));
        check({tag, "_start"},    64'(bus.start),    64'(0));
        check({tag, "_busy"},     64'(bus.busy),     64'(0));
        check({tag, "_error"},    64'(bus.error),    64'(0));
    endtask

    // Asynchronous assertion mid-cycle; outputs must clear without waiting for a clock.
    task automatic pulse_reset(input bit check_outputs, input string tag);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        if (check_outputs) check_reset_outputs(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle before each word, 2 random 0..3 idle cycles.
    task automatic send_word(input logic [DW-1:0] w, input int gap_mode, output bit ok);
        int idle;
        int budget;
        idle = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
        bus.in_valid = 1'b0;
        repeat (idle) @(negedge clk);
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        budget = 0;
        while (bus.in_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        ok = (budget < 50);
        if (ok) @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_job(input int m, input int n, input int p, input int gap_mode,
                           input bit seq_data, input int abort_after, input string tag);
        logic [DW-1:0] words[$];
        int  total, base, mism, budget;
        bit  ok;

        words.delete();
        words.push_back(DW'(m));
        words.push_back(DW'(n));
        words.push_back(DW'(p));
        for (int i = 0; i < m * n + n * p; i++)
            words.push_back(seq_data ? DW'(i + 1) : DW'($urandom));

        total = 3 + m * n + n * p;
        base  = 3 + m * n;
        exp_mem[0] = DW'(m);
        exp_mem[1] = DW'(n);
        exp_mem[2] = DW'(p);
        for (int i = 0; i < m; i++)
            for (int k = 0; k < n; k++)
                exp_mem[3 + i * n + k] = words[3 + i * n + k];
        for (int k = 0; k < n; k++)
            for (int j = 0; j < p; j++)
`ifdef LOADER_TRANSPOSE_B_EN
                exp_mem[base + j * n + k] = words[base + k * p + j];
`else
                exp_mem[base + k * p + j] = words[base + k * p + j];
`endif

        clear_log();
        for (int i = 0; i < words.size(); i++) begin
            send_word(words[i], gap_mode, ok);
            if (!ok) begin
                check({tag, "_ready_timeout"}, 64'(0), 64'(1));
                return;
            end
            if (abort_after == i + 1) begin
                reset = 1'b0;
                #1;
                check_reset_outputs({tag, "_midreset"});
                @(negedge clk);
                reset = 1'b1;
                return;
            end
        end

        budget = 0;
        while (start_cnt == 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check({tag, "_start_seen"}, 64'(start_cnt > 0), 64'(1));
        check({tag, "_write_count"}, 64'(wr_cnt), 64'(total));
        mism = 0;
        for (int a = 0; a < total; a++)
            if (!wr_flag[a] || wr_mem[a] !== exp_mem[a]) mism++;
        check({tag, "_image_mismatches"}, 64'(mism), 64'(0));
        check({tag, "_start_after_last_write"}, 64'(start_cyc), 64'(last_wr_cyc + 1));

        repeat (3) @(negedge clk);
        check({tag, "_start_once"},    64'(start_cnt),    64'(1));
        check({tag, "_busy_in_wait"},  64'(bus.busy),     64'(1));
        check({tag, "_ready_in_wait"}, 64'(bus.in_ready), 64'(0));
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        check({tag, "_idle_after_result"}, 64'(bus.busy), 64'(0));
    endtask

    task automatic run_bad_header(input int m, input int n, input int p, input int nwords,
                                  input int good_writes, input string tag);
        int dims[3];
        bit ok;
        dims[0] = m;
        dims[1] = n;
        dims[2] = p;
        clear_log();
        for (int i = 0; i < nwords; i++) begin
            send_word(DW'(dims[i]), 0, ok);
            if (!ok) begin
                check({tag, "_ready_timeout"}, 64'(0), 64'(1));
                return;
            end
        end
        repeat (3) @(negedge clk);
        check({tag, "_error"},       64'(bus.error),    64'(1));
        check({tag, "_in_ready"},    64'(bus.in_ready), 64'(0));
        check({tag, "_write_count"}, 64'(wr_cnt),       64'(good_writes));
        if (good_writes < 3)
            check({tag, "_bad_word_unwritten"}, 64'(wr_flag[good_writes]), 64'(0));
        repeat (10) @(negedge clk);
        check({tag, "_error_sticky"}, 64'(bus.error), 64'(1));
        check({tag, "_no_late_write"}, 64'(wr_cnt), 64'(good_writes));
        pulse_reset(1'b0, tag);
        check({tag, "_error_cleared"}, 64'(bus.error), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_data      = '0;
        bus.in_valid     = 1'b0;
        bus.result_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_job(2, 3, 2, 0, 1'b1, 0, "plan_232");
`ifdef LOADER_TRANSPOSE_B_EN
        check("plan_addr10", 64'(wr_mem[10]), 64'(9));
        check("plan_addr12", 64'(wr_mem[12]), 64'(8));
`else
        check("plan_addr10", 64'(wr_mem[10]), 64'(8));
        check("plan_addr12", 64'(wr_mem[12]), 64'(10));
`endif
        check("plan_addr8", 64'(wr_mem[8]), 64'(6));

        run_job(2, 3, 2, 1, 1'b1, 0, "toggle_232");

        for (int r = 0; r < 6; r++)
            run_job(int'($urandom_range(1, 7)), int'($urandom_range(1, 7)),
                    int'($urandom_range(1, 7)), 2, 1'b0, 0, $sformatf("rand%0d", r));

        run_job(2, 3, 2, 0, 1'b1, 7, "abort");
        run_job(3, 2, 4, 2, 1'b0, 0, "after_abort");

        run_bad_header(0, 3, 2, 1, 0, "m_zero");
        run_bad_header(2, 101, 2, 2, 1, "n_101");
        run_bad_header(37, 37, 37, 3, 3, "cap_37");

        run_job(36, 36, 36, 0, 1'b0, 0, "cap_36");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
